bcd_convert_scheduler: RTL and testbench
========================================

BCD_CONVERT_SCHEDULER -- requirements
Module: bcd_convert_scheduler

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; no other clock or asynchronous input.
REQ-002 The ports SHALL be, in order:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- req  in  2  conversion request, bit n from requester n
- data0  in  16  binary value of requester 0
- data1  in  16  binary value of requester 1
- grant  out  2  one-hot, one-cycle pulse naming the accepted requester
- busy  out  1  conversion in progress (state SHIFT or DONE)
- done  out  1  one-cycle pulse, result digits valid
- done_id  out  1  requester that owns the current result
- thousand, hundred, ten, one  out  4 each  registered BCD result digits
- overflow  out  1  captured value exceeded 9999 (see Configuration)
REQ-003 The block SHALL have no parameters; the data width is fixed at 16 bits and the digit count at 4.

Function
REQ-004 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-005 IDLE, req != 0 at edge E0: SHALL capture the selected requester's data into a 16-bit shift register, clear the working digits, clear the bit counter, register the one-hot grant and go to SHIFT.
REQ-006 Arbitration SHALL be round-robin: if only one req bit is set, that requester wins; if both are set, the requester not granted last wins; after reset, requester 0 wins a tie.
REQ-007 grant SHALL be high only during the cycle after E0; req SHALL be ignored in SHIFT and DONE, and a requester holds req until it sees grant.
REQ-008 Each SHIFT edge SHALL do one double-dabble step: add 3 to every working digit >= 5, then shift {thousand, hundred, ten, one, shift-reg} left by one, MSB first; the bit leaving thousand[3] is discarded.
REQ-009 SHIFT SHALL last exactly 16 edges (E1..E16). At E16: load the output digits, set done_id, go to DONE.
REQ-010 In DONE, done SHALL be 1 for exactly one cycle (E16..E17). At E17 the FSM goes to IDLE, and it accepts the next request no earlier than E18.
REQ-011 Output digits and done_id SHALL hold their last value until the next E16, and SHALL NOT change during SHIFT.
REQ-012 busy SHALL be 1 from E0+ through E17-; latency from request acceptance to done = 16 cycles; request-to-request spacing >= 18 cycles.
REQ-013 An input of 0 SHALL produce 0,0,0,0; 9999 SHALL produce 9,9,9,9 with overflow 0.

Reset
REQ-014 With reset high at an edge: state = IDLE; grant, busy, done, done_id, overflow and all digits = 0; the round-robin pointer favours requester 0.
REQ-015 Reset during SHIFT or DONE SHALL abort the conversion with no done pulse, and outputs SHALL NOT retain the partial result.
REQ-016 Reset SHALL take precedence over a simultaneous request.

Configuration
REQ-017 Macro BCD_SATURATE_EN defined: a captured value > 9999 SHALL set the output digits to 9,9,9,9 and overflow to 1 at E16; overflow SHALL be 0 for values <= 9999.
REQ-018 Macro BCD_SATURATE_EN undefined: the digits SHALL equal value mod 10000, and overflow SHALL be constant 0.

Verification
REQ-019 The bench SHALL cover these scenarios:
- req=01, data0=1234 -> grant=01 at E0+1; done at E16+ with digits 1,2,3,4 and done_id=0; busy high 17 cycles.
- req=11 held, data0=42, data1=7 -> first grant=01 (result 0,0,4,2), then grant=10 (result 0,0,0,7); a third tie goes back to requester 0.
- req=10, data1=65535 -> with BCD_SATURATE_EN: 9,9,9,9 and overflow=1; without it: 5,5,3,5 and overflow=0.
- data0=0, then data0=9999 -> 0,0,0,0, then 9,9,9,9 with overflow=0 in both builds.
- Reset asserted at E8 of a conversion of 1234 -> no done pulse, all outputs 0, state IDLE; the next req=01 converts normally.
- req raised during SHIFT by the other requester -> no grant until E18 or later; digits stable throughout SHIFT.

Source files
------------

// File: rtl/bcd_convert_scheduler.sv
// bcd_convert_scheduler: round-robin front end for two requesters feeding a
// serial 16-bit binary-to-BCD (double-dabble) converter with 4 result digits.
// Build macro BCD_SATURATE_EN: when defined, captured values above 9999 give
// 9,9,9,9 with overflow set; when undefined, digits wrap modulo 10000 and
// overflow stays 0.
`timescale 1ns/1ps
module bcd_convert_scheduler (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [15:0] data0,
    input  logic [15:0] data1,
    output logic [1:0]  grant,
    output logic        busy,
    output logic        done,
    output logic        done_id,
    output logic [3:0]  thousand,
    output logic [3:0]  hundred,
    output logic [3:0]  ten,
    output logic [3:0]  one,
    output logic        overflow
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state_q, state_d;
    logic [15:0] shift_reg;
    logic [15:0] work;
    logic [14:0] adj;
    logic [15:0] work_next;
    logic [3:0]  bit_cnt;
    logic        last_step;
    logic [1:0]  grant_q;
    logic        cur_id;
    logic        last_id;
    logic        pick_id;
    logic [15:0] sel_data;
    logic [15:0] result_q;
    logic        done_id_q;
`ifdef BCD_SATURATE_EN
    logic        big_q;
    logic        ovf_q;
`endif

    // Round-robin pick: a lone request wins, a tie goes to the requester not served last
    always_comb begin
        pick_id = 1'b0;
        case (req)
            2'b10:   pick_id = 1'b1;
            2'b11:   pick_id = ~last_id;
            default: pick_id = 1'b0;
        endcase
        sel_data = pick_id ? data1 : data0;
    end

    // One double-dabble step: correct digits >= 5, then shift in the next binary bit;
    // only the low three bits of the corrected thousands digit survive the shift
    always_comb begin
        adj = '0;
        for (int i = 0; i < 3; i++) begin
            adj[i*4 +: 4] = (work[i*4 +: 4] >= 4'd5) ? work[i*4 +: 4] + 4'd3 : work[i*4 +: 4];
        end
        adj[14:12] = work[14:12] + ((work[15:12] >= 4'd5) ? 3'd3 : 3'd0);
        work_next  = {adj, shift_reg[15]};
        last_step  = (bit_cnt == 4'd15);
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic: 16 shift cycles, then a single DONE cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req != 2'b00) state_d = SHIFT;
            SHIFT:   if (last_step)    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: capture on acceptance, shift during SHIFT, publish results on the last step
    always_ff @(posedge clock) begin
        if (reset) begin
            shift_reg <= '0;
            work      <= '0;
            bit_cnt   <= '0;
            grant_q   <= '0;
            cur_id    <= 1'b0;
            last_id   <= 1'b1;
            result_q  <= '0;
            done_id_q <= 1'b0;
`ifdef BCD_SATURATE_EN
            big_q     <= 1'b0;
            ovf_q     <= 1'b0;
`endif
        end else begin
            grant_q <= 2'b00;
            case (state_q)
                IDLE: begin
                    if (req != 2'b00) begin
                        shift_reg <= sel_data;
                        work      <= '0;
                        bit_cnt   <= '0;
                        grant_q   <= pick_id ? 2'b10 : 2'b01;
                        cur_id    <= pick_id;
                        last_id   <= pick_id;
`ifdef BCD_SATURATE_EN
                        big_q     <= (sel_data > 16'd9999);
`endif
                    end
                end
                SHIFT: begin
                    work      <= work_next;
                    shift_reg <= {shift_reg[14:0], 1'b0};
                    bit_cnt   <= bit_cnt + 4'd1;
                    if (last_step) begin
                        done_id_q <= cur_id;
`ifdef BCD_SATURATE_EN
                        if (big_q) begin
                            result_q <= 16'h9999;
                            ovf_q    <= 1'b1;
                        end else begin
                            result_q <= work_next;
                            ovf_q    <= 1'b0;
                        end
`else
                        result_q <= work_next;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign grant    = grant_q;
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign done_id  = done_id_q;
    assign thousand = result_q[15:12];
    assign hundred  = result_q[11:8];
    assign ten      = result_q[7:4];
    assign one      = result_q[3:0];
`ifdef BCD_SATURATE_EN
    assign overflow = ovf_q;
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_convert_scheduler.sv
// tb_bcd_convert_scheduler: scenario tasks with a scoreboard queue of expected
// conversion results, pushed on grant and popped on done.
`timescale 1ns/1ps
module tb_bcd_convert_scheduler;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req   = 2'b00;
    logic [15:0] data0 = '0;
    logic [15:0] data1 = '0;
    logic [1:0]  grant;
    logic        busy, done, done_id, overflow;
    logic [3:0]  thousand, hundred, ten, one;

    typedef struct packed {
        logic [15:0] digits;
        logic        ovf;
        logic        id;
    } exp_t;

    exp_t sb[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    bcd_convert_scheduler dut (
        .clock(clock), .reset(reset), .req(req), .data0(data0), .data1(data1),
        .grant(grant), .busy(busy), .done(done), .done_id(done_id),
        .thousand(thousand), .hundred(hundred), .ten(ten), .one(one),
        .overflow(overflow)
    );

    // Free-running clock, 10 ns period
    always #5 clock = ~clock;

    // Watchdog so the run can never hang
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference model: decimal digits by division, optional saturation
    function automatic exp_t model(input logic [15:0] v, input logic id);
        exp_t e;
        int   n;
        int   m;
        n = int'(v);
        e.id  = id;
        e.ovf = 1'b0;
`ifdef BCD_SATURATE_EN
        if (n > 9999) begin
            e.digits = 16'h9999;
            e.ovf    = 1'b1;
            return e;
        end
`endif
        m = n % 10000;
        e.digits = {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
        return e;
    endfunction

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Wait for a grant pulse; g stays 0 if none appears within the budget
    task automatic wait_grant(input int budget, output logic [1:0] g, output int cycles);
        g = 2'b00;
        cycles = 0;
        while (cycles < budget) begin
            tick();
            cycles++;
            if (grant != 2'b00) begin
                g = grant;
                break;
            end
        end
    endtask

    // Wait for done while recording busy cycles, stray grants and digit movement
    task automatic wait_done(input int budget, output int cycles, output int busy_cnt,
                             output bit stray, output bit moved);
        logic [15:0] snap;
        snap     = {thousand, hundred, ten, one};
        cycles   = 0;
        busy_cnt = busy ? 1 : 0;
        stray    = 1'b0;
        moved    = 1'b0;
        while (cycles < budget) begin
            tick();
            cycles++;
            if (busy) busy_cnt++;
            if (done) break;
            if (grant != 2'b00) stray = 1'b1;
            if ({thousand, hundred, ten, one} != snap) moved = 1'b1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        req   = 2'b11;
        data0 = 16'd5;
        data1 = 16'd6;
        tick();
        tick();
        total_cnt++; if (grant !== 2'b00) $display("[TB] FAIL reset_grant: got %b expected 00", grant); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", done); else pass_cnt++;
        total_cnt++; if (done_id !== 1'b0) $display("[TB] FAIL reset_done_id: got %b expected 0", done_id); else pass_cnt++;
        total_cnt++; if ({thousand, hundred, ten, one} !== 16'h0000) $display("[TB] FAIL reset_digits: got %h expected 0000", {thousand, hundred, ten, one}); else pass_cnt++;
        total_cnt++; if (overflow !== 1'b0) $display("[TB] FAIL reset_overflow: got %b expected 0", overflow); else pass_cnt++;
        req   = 2'b00;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_tie;
        logic [1:0] g;
        int c, bc;
        bit st, mv;
        exp_t e;
        data0 = 16'd42;
        data1 = 16'd7;
        for (int round = 0; round < 3; round++) begin
            logic [1:0] want;
            want = (round == 1) ? 2'b10 : 2'b01;
            if (round != 1) req = 2'b11;
            wait_grant(30, g, c);
            total_cnt++; if (g !== want) $display("[TB] FAIL tie_grant_%0d: got %b expected %b", round, g, want); else pass_cnt++;
            sb.push_back(model(want[1] ? data1 : data0, want[1]));
            req = req & ~want;
            wait_done(40, c, bc, st, mv);
            total_cnt++; if (c !== 16) $display("[TB] FAIL tie_latency_%0d: got %0d expected 16", round, c); else pass_cnt++;
            if (round == 2) req = 2'b00;
            if (sb.size() == 0) begin
                total_cnt++; $display("[TB] FAIL tie_scoreboard_%0d: got empty queue expected entry", round);
            end else begin
                e = sb.pop_front();
                total_cnt++; if ({thousand, hundred, ten, one} !== e.digits) $display("[TB] FAIL tie_digits_%0d: got %h expected %h", round, {thousand, hundred, ten, one}, e.digits); else pass_cnt++;
                total_cnt++; if (done_id !== e.id) $display("[TB] FAIL tie_done_id_%0d: got %b expected %b", round, done_id, e.id); else pass_cnt++;
            end
        end
        tick();
        tick();
    endtask

    // Single request from one requester with full timing checks
    task automatic test_single(input string name, input logic [1:0] r, input logic [15:0] v);
        logic [1:0] g;
        int c, bc;
        bit st, mv;
        exp_t e;
        if (r[1]) data1 = v; else data0 = v;
        req = r;
        wait_grant(30, g, c);
        total_cnt++; if (g !== r) $display("[TB] FAIL %s_grant: got %b expected %b", name, g, r); else pass_cnt++;
        sb.push_back(model(v, r[1]));
        req = 2'b00;
        wait_done(40, c, bc, st, mv);
        total_cnt++; if (c !== 16) $display("[TB] FAIL %s_latency: got %0d expected 16", name, c); else pass_cnt++;
        total_cnt++; if (bc !== 17) $display("[TB] FAIL %s_busy_cycles: got %0d expected 17", name, bc); else pass_cnt++;
        total_cnt++; if (st !== 1'b0) $display("[TB] FAIL %s_grant_width: got extra grant %b expected none", name, st); else pass_cnt++;
        total_cnt++; if (mv !== 1'b0) $display("[TB] FAIL %s_digits_stable: got moved=%b expected 0", name, mv); else pass_cnt++;
        if (sb.size() == 0) begin
            total_cnt++; $display("[TB] FAIL %s_scoreboard: got empty queue expected entry", name);
        end else begin
            e = sb.pop_front();
            total_cnt++; if ({thousand, hundred, ten, one} !== e.digits) $display("[TB] FAIL %s_digits: got %h expected %h", name, {thousand, hundred, ten, one}, e.digits); else pass_cnt++;
            total_cnt++; if (done_id !== e.id) $display("[TB] FAIL %s_done_id: got %b expected %b", name, done_id, e.id); else pass_cnt++;
            total_cnt++; if (overflow !== e.ovf) $display("[TB] FAIL %s_overflow: got %b expected %b", name, overflow, e.ovf); else pass_cnt++;
        end
        tick();
        total_cnt++; if (done !== 1'b0 || busy !== 1'b0) $display("[TB] FAIL %s_after_done: got done=%b busy=%b expected 0 0", name, done, busy); else pass_cnt++;
    endtask

    task automatic test_mid_reset;
        logic [1:0] g;
        int c;
        bit saw_done;
        data0 = 16'd1234;
        req   = 2'b01;
        wait_grant(30, g, c);
        req = 2'b00;
        for (int i = 0; i < 7; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total_cnt++; if (busy !== 1'b0) $display("[TB] FAIL midreset_busy: got %b expected 0", busy); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("[TB] FAIL midreset_done: got %b expected 0", done); else pass_cnt++;
        total_cnt++; if ({thousand, hundred, ten, one} !== 16'h0000) $display("[TB] FAIL midreset_digits: got %h expected 0000", {thousand, hundred, ten, one}); else pass_cnt++;
        total_cnt++; if (done_id !== 1'b0 || overflow !== 1'b0 || grant !== 2'b00) $display("[TB] FAIL midreset_flags: got id=%b ovf=%b grant=%b expected 0 0 00", done_id, overflow, grant); else pass_cnt++;
        saw_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) saw_done = 1'b1;
        end
        total_cnt++; if (saw_done !== 1'b0) $display("[TB] FAIL midreset_no_done: got done pulse expected none"); else pass_cnt++;
        test_single("after_reset", 2'b01, 16'd1234);
    endtask

    task automatic test_collision;
        logic [1:0] g;
        int c, c2, bc;
        bit st, mv;
        exp_t e;
        data0 = 16'd1234;
        data1 = 16'd321;
        req   = 2'b01;
        wait_grant(30, g, c);
        req = 2'b00;
        for (int i = 0; i < 5; i++) tick();
        req = 2'b10;
        wait_done(40, c, bc, st, mv);
        total_cnt++; if (5 + c !== 16) $display("[TB] FAIL collision_latency: got %0d expected 16", 5 + c); else pass_cnt++;
        total_cnt++; if (st !== 1'b0) $display("[TB] FAIL collision_no_grant_in_shift: got stray=%b expected 0", st); else pass_cnt++;
        total_cnt++; if (mv !== 1'b0) $display("[TB] FAIL collision_digits_stable: got moved=%b expected 0", mv); else pass_cnt++;
        wait_grant(10, g, c2);
        total_cnt++; if (g !== 2'b10) $display("[TB] FAIL collision_second_grant: got %b expected 10", g); else pass_cnt++;
        total_cnt++; if (16 + c2 < 18) $display("[TB] FAIL collision_spacing: got %0d expected >=18", 16 + c2); else pass_cnt++;
        sb.push_back(model(16'd321, 1'b1));
        req = 2'b00;
        wait_done(40, c, bc, st, mv);
        if (sb.size() == 0) begin
            total_cnt++; $display("[TB] FAIL collision_scoreboard: got empty queue expected entry");
        end else begin
            e = sb.pop_front();
            total_cnt++; if ({thousand, hundred, ten, one} !== e.digits) $display("[TB] FAIL collision_digits: got %h expected %h", {thousand, hundred, ten, one}, e.digits); else pass_cnt++;
            total_cnt++; if (done_id !== e.id) $display("[TB] FAIL collision_done_id: got %b expected %b", done_id, e.id); else pass_cnt++;
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_tie();
        test_single("single_1234", 2'b01, 16'd1234);
        test_single("saturate_65535", 2'b10, 16'd65535);
        test_single("edge_zero", 2'b01, 16'd0);
        test_single("edge_9999", 2'b01, 16'd9999);
        test_mid_reset();
        test_collision();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
